io_serial_tx: RTL and testbench
===============================

// Module: io_serial_tx
// PURPOSE
//  Memory-mapped serial transmitter. It is the device-side responder on the CPU I/O bus (the addr[7]=1 space).
//  The CPU writes a byte to the DATA register; the block buffers it and serializes it as 8N1 on txd.
//  A STATUS register lets the program poll for free space, busy and overrun.
//  Peer of the io_output/io_input port registers; driven by the same write_io_enable/dmem_clk path.
// PARAMETERS
//  CLKS_PER_BIT  16     clock cycles per serial bit (>=2)
//  ADDR_DATA     8'h80  byte address of DATA register (decode compares addr[7:2])
//  ADDR_STAT     8'h84  byte address of STATUS register (decode compares addr[7:2])
// PORTS
//  clock    in   1   single clock; all state updates on rising edge
//  resetn   in   1   reset, asynchronous, active-low
//  addr     in   32  CPU byte address; only addr[7:2] decoded
//  datain   in   32  CPU write data
//  we       in   1   I/O write strobe, already qualified for the I/O space
//  dataout  out  32  read data, combinational from addr
//  txd      out  1   serial output, idle high
//  busy     out  1   1 while a frame is on the line (state != IDLE)
//  tx_done  out  1   one-cycle pulse at end of each stop bit
// BEHAVIOUR
//  Reset (async, resetn=0): txd=1, busy=0, tx_done=0, hold_valid=0, overrun=0, state=IDLE, counters=0.
//   A reset mid-frame forces txd=1 immediately. The frame is abandoned with no tx_done.
//  Storage: 1-byte holding register hold (+hold_valid) and 8-bit shift register. Total buffering is 2 bytes.
//  DATA write (we & addr[7:2]==ADDR_DATA[7:2]):
//   - hold_valid=0 -> hold<=datain[7:0], hold_valid<=1.
//   - hold_valid=1 and FSM consumes hold on the same edge -> write accepted, hold_valid stays 1.
//   - otherwise the write is dropped and sticky overrun<=1. hold is unchanged.
//  STAT write: datain[2]=1 clears overrun. If a dropped DATA write and a clear land on the same edge, set wins.
//  Writes to any other address are ignored.
//  Reads, combinational:
//   - ADDR_STAT -> {29'b0, overrun, busy, hold_valid}
//   - ADDR_DATA -> {24'b0, hold}
//   - others -> 32'b0
//  FSM states:
//   IDLE:  txd=1. If hold_valid: shift<=hold, hold_valid<=0, go to START.
//   START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//   DATA:  txd=shift[0], LSB first. Each CLKS_PER_BIT cycles shift right and bit_idx++.
//          After bit 7 go to STOP.
//   STOP:  txd=1 for CLKS_PER_BIT cycles. On the last cycle tx_done=1.
//          If hold_valid, load shift and go directly to START (no idle gap); else go to IDLE.
//  Baud counter counts 0..CLKS_PER_BIT-1 and wraps; it is reset to 0 on every state change.
//  Latency:
//   - DATA write accepted at edge N -> hold_valid=1 after N.
//   - From IDLE, FSM loads at edge N+1; txd falls after edge N+1.
//   - Frame = 10*CLKS_PER_BIT cycles.
//  txd, busy and tx_done are registered outputs (glitch-free).
// TESTING (CLKS_PER_BIT=4)
//  1. Reset -> txd=1, busy=0; read ADDR_STAT=0; read ADDR_DATA=0.
//  2. Write 0x55 to 0x80 -> txd=0 one cycle later for 4 cycles; then 1,0,1,0,1,0,1,0 at 4 cycles each;
//     stop=1; tx_done pulse 40 cycles after start; busy drops after.
//  3. Write 0xA5 then 0x3C while busy -> 0x3C start bit immediately follows 0xA5 stop bit, no idle cycle.
//  4. Three DATA writes during one frame -> third dropped; STAT reads 0x7; write 0x4 to 0x84 -> STAT 0x3.
//  5. Assert resetn=0 during DATA bit 3 -> txd=1 asynchronously, STAT=0, no tx_done; next write sends a clean frame.
//  6. Write to 0x88 and read it -> no state change, dataout=0; DATA write same edge as IDLE load -> accepted, no overrun.

Source files
------------

// File: rtl/io_serial_tx.sv
// Memory-mapped 8N1 serial transmitter on the CPU I/O bus.
// It has a DATA register with a one-byte holding buffer, a STATUS register, and a registered txd/busy/tx_done.
module io_serial_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  ADDR_DATA    = 8'h80,
  parameter logic [7:0]  ADDR_STAT    = 8'h84
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  output logic        txd,
  output logic        busy,
  output logic        tx_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic [7:0]      hold_r;
  logic            hold_valid_r;
  logic            overrun_r;
  logic            txd_r;
  logic            busy_r;
  logic            tx_done_r;

  logic            sel_data_s;
  logic            sel_stat_s;
  logic            wr_data_s;
  logic            wr_stat_s;
  logic            baud_last_s;
  logic            consume_s;
  logic            drop_s;
  logic            unused_s;

  assign sel_data_s  = (addr[7:2] == ADDR_DATA[7:2]);
  assign sel_stat_s  = (addr[7:2] == ADDR_STAT[7:2]);
  assign wr_data_s   = we & sel_data_s;
  assign wr_stat_s   = we & sel_stat_s;
  assign baud_last_s = (cnt_r == BAUD_LAST);
  // The FSM takes the holding byte on this edge, so a DATA write here refills it.
  assign consume_s   = hold_valid_r &
                       ((state_r == ST_IDLE) | ((state_r == ST_STOP) & baud_last_s));
  assign drop_s      = wr_data_s & hold_valid_r & ~consume_s;
  assign unused_s    = ^{addr[31:8], addr[1:0], datain[31:8]};

  assign txd     = txd_r;
  assign busy    = busy_r;
  assign tx_done = tx_done_r;

  // Register read mux.
  always_comb begin
    dataout = 32'h0000_0000;
    if (sel_stat_s) begin
      dataout = {29'b0, overrun_r, busy_r, hold_valid_r};
    end else if (sel_data_s) begin
      dataout = {24'b0, hold_r};
    end else begin
      dataout = 32'h0000_0000;
    end
  end

  // Holding register and sticky overrun flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hold_r       <= 8'h00;
      hold_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (wr_data_s && (!hold_valid_r || consume_s)) begin
        hold_r       <= datain[7:0];
        hold_valid_r <= 1'b1;
      end else if (consume_s) begin
        hold_valid_r <= 1'b0;
      end else begin
        hold_valid_r <= hold_valid_r;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (wr_stat_s && datain[2]) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Frame FSM; txd is driven with the value the next state needs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (hold_valid_r) begin
            shift_r <= hold_r;
            state_r <= ST_START;
            txd_r   <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_last_s) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            state_r   <= ST_DATA;
            txd_r     <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last_s) begin
            cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
              txd_r   <= 1'b1;
            end else begin
              shift_r   <= shift_r >> 1;
              txd_r     <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_STOP: begin
          if (baud_last_s) begin
            cnt_r <= '0;
            if (hold_valid_r) begin
              shift_r <= hold_r;
              state_r <= ST_START;
              txd_r   <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              txd_r   <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r     <= cnt_r + CW'(1);
            // Raised one cycle early so the registered pulse covers the final stop cycle.
            tx_done_r <= (cnt_r == BAUD_PRE);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          txd_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_serial_tx.sv
// Directed bench for io_serial_tx with CLKS_PER_BIT=4: register decode table plus frame-level sequences.
module tb_io_serial_tx;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;
  logic        txd;
  logic        busy;
  logic        tx_done;

  int checks;
  int errors;

  io_serial_tx #(.CLKS_PER_BIT(4), .ADDR_DATA(8'h80), .ADDR_STAT(8'h84)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .addr    (addr),
    .datain  (datain),
    .we      (we),
    .dataout (dataout),
    .txd     (txd),
    .busy    (busy),
    .tx_done (tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    addr = a;
    datain = d;
    we = 1'b1;
    @(posedge clock);
    #1 we = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 chk(name, dataout, exp);
  endtask

  // Samples 40 consecutive negedges starting at frame cycle 0.
  task automatic check_frame(input logic [7:0] b, input string tag);
    int bad_txd;
    int bad_done;
    int bad_busy;
    logic exp_txd;
    bad_txd = 0;
    bad_done = 0;
    bad_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (c < 4) exp_txd = 1'b0;
      else if (c < 36) exp_txd = b[(c - 4) / 4];
      else exp_txd = 1'b1;
      if (txd !== exp_txd) bad_txd++;
      if (tx_done !== (c == 39)) bad_done++;
      if (busy !== 1'b1) bad_busy++;
    end
    chk({tag, "_txd_bad_cycles"}, bad_txd, 0);
    chk({tag, "_tx_done_bad_cycles"}, bad_done, 0);
    chk({tag, "_busy_bad_cycles"}, bad_busy, 0);
  endtask

  initial begin
    int n;
    int pulses;
    int glitches;
    checks = 0;
    errors = 0;
    we = 1'b0;
    addr = 32'h0;
    datain = 32'h0;
    resetn = 1'b1;

    vecs[0] = '{1'b0, 32'h00, 32'h0000_0000, 32'h84,  32'h00};
    vecs[1] = '{1'b0, 32'h00, 32'h0000_0000, 32'h80,  32'h55};
    vecs[2] = '{1'b1, 32'h88, 32'h0000_00FF, 32'h88,  32'h00};
    vecs[3] = '{1'b1, 32'h00, 32'h0000_00AA, 32'h84,  32'h00};
    vecs[4] = '{1'b1, 32'h7C, 32'h0000_0012, 32'h80,  32'h55};
    vecs[5] = '{1'b0, 32'h00, 32'h0000_0000, 32'h83,  32'h55};
    vecs[6] = '{1'b0, 32'h00, 32'h0000_0000, 32'h180, 32'h55};
    vecs[7] = '{1'b1, 32'h86, 32'hFFFF_FFFF, 32'h84,  32'h00};
    vecs[8] = '{1'b0, 32'h00, 32'h0000_0000, 32'h87,  32'h00};
    vecs[9] = '{1'b1, 32'hC0, 32'h0000_0077, 32'h80,  32'h55};

    // Reset state
    #2 resetn = 1'b0;
    #10;
    chk("reset_txd", {31'b0, txd}, 32'h1);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_tx_done", {31'b0, tx_done}, 32'h0);
    read_chk("reset_stat", 32'h84, 32'h0);
    read_chk("reset_data", 32'h80, 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // Single frame 0x55
    do_write(32'h80, 32'h55);
    @(negedge clock);
    chk("pre_start_txd", {31'b0, txd}, 32'h1);
    read_chk("pre_start_stat", 32'h84, 32'h1);
    check_frame(8'h55, "f55");
    @(negedge clock);
    chk("post55_busy", {31'b0, busy}, 32'h0);
    chk("post55_txd", {31'b0, txd}, 32'h1);
    read_chk("post55_stat", 32'h84, 32'h0);

    // Decode table, hold holds 0x55
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (vecs[i].wr) begin
        addr = vecs[i].waddr;
        datain = vecs[i].wdata;
        we = 1'b1;
        @(posedge clock);
        #1 we = 1'b0;
      end
      read_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end
    chk("table_busy", {31'b0, busy}, 32'h0);
    chk("table_txd", {31'b0, txd}, 32'h1);

    // Back-to-back frames with a write while busy
    do_write(32'h80, 32'hA5);
    @(negedge clock);
    fork
      check_frame(8'hA5, "fA5");
      begin
        repeat (10) @(negedge clock);
        addr = 32'h80;
        datain = 32'h3C;
        we = 1'b1;
        @(posedge clock);
        #1 we = 1'b0;
      end
    join
    check_frame(8'h3C, "f3C");
    @(negedge clock);
    chk("post3C_busy", {31'b0, busy}, 32'h0);

    // Overrun: third write dropped, then cleared
    do_write(32'h80, 32'h11);
    do_write(32'h80, 32'h22);
    do_write(32'h80, 32'h33);
    read_chk("ovr_stat", 32'h84, 32'h7);
    read_chk("ovr_data_kept", 32'h80, 32'h22);
    do_write(32'h84, 32'h4);
    read_chk("ovr_cleared_stat", 32'h84, 32'h3);
    n = 0;
    pulses = 0;
    @(negedge clock);
    while (busy === 1'b1 && n < 300) begin
      if (tx_done === 1'b1) pulses++;
      @(negedge clock);
      n++;
    end
    chk("ovr_wait_timeout", {31'b0, (n >= 300)}, 32'h0);
    chk("ovr_frame_count", pulses, 2);
    read_chk("ovr_final_stat", 32'h84, 32'h0);

    // Reset mid-frame during data bit 3
    do_write(32'h80, 32'h00);
    @(negedge clock);
    repeat (18) @(negedge clock);
    chk("bit3_txd_low", {31'b0, txd}, 32'h0);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_txd", {31'b0, txd}, 32'h1);
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_done", {31'b0, tx_done}, 32'h0);
    read_chk("async_rst_stat", 32'h84, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    glitches = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (tx_done !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) glitches++;
    end
    chk("post_rst_quiet", glitches, 0);
    do_write(32'h80, 32'hC3);
    @(negedge clock);
    check_frame(8'hC3, "fC3");

    // DATA write on the same edge as the IDLE load
    @(negedge clock);
    do_write(32'h80, 32'h11);
    do_write(32'h80, 32'h22);
    read_chk("same_edge_stat", 32'h84, 32'h3);
    check_frame(8'h11, "f11");
    check_frame(8'h22, "f22");
    @(negedge clock);
    chk("final_busy", {31'b0, busy}, 32'h0);
    read_chk("final_stat", 32'h84, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
